// File: rtl/wb_bayer_gen.sv
// wb_bayer_gen: Bayer-order test-pattern source with sensor-style fval/lval timing.
// Geometry, colour values and pattern mode are captured into shadows at each frame start.
module wb_bayer_gen #(
    parameter BAYER_PATTERN = "GR",
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int GEOM_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_enable,
    input  logic                        i_pattern_sel,
    input  logic [GEOM_WIDTH-1:0]       iv_width,
    input  logic [GEOM_WIDTH-1:0]       iv_height,
    input  logic [GEOM_WIDTH-1:0]       iv_h_blank,
    input  logic [GEOM_WIDTH-1:0]       iv_v_blank,
    input  logic [SENSOR_DAT_WIDTH-1:0] iv_r_value,
    input  logic [SENSOR_DAT_WIDTH-1:0] iv_g_value,
    input  logic [SENSOR_DAT_WIDTH-1:0] iv_b_value,
    output logic                        o_fval,
    output logic                        o_lval,
    output logic [SENSOR_DAT_WIDTH-1:0] ov_pix_data,
    output logic                        o_frame_done
);
    localparam logic [GEOM_WIDTH-1:0] one = {{(GEOM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic pat_gr = (BAYER_PATTERN == "GR");
    localparam logic pat_rg = (BAYER_PATTERN == "RG");
    localparam logic pat_gb = (BAYER_PATTERN == "GB");
    localparam logic pat_bg = (BAYER_PATTERN == "BG");
    localparam logic pat_ok = pat_gr | pat_rg | pat_gb | pat_bg;
    // green sits where line and column parity agree for G-first orders
    localparam logic g_even = pat_gr | pat_gb;
    localparam logic r_row0 = pat_gr | pat_rg;

    typedef enum logic [2:0] {IDLE, FV_SETUP, LINE_ACT, LINE_BLANK, V_BLANK} state_t;

    state_t                      state, state_n;
    logic [GEOM_WIDTH-1:0]       cnt, cnt_n, line, line_n, sum;
    logic [GEOM_WIDTH-1:0]       width_s, height_s, hb_s, vb_s;
    logic [SENSOR_DAT_WIDTH-1:0] r_s, g_s, b_s, flat_v, pix_n;
    logic                        ramp_s, go, latch, lp, cp;

    always_comb begin
        go = i_enable && (iv_width != '0) && (iv_height != '0);
        state_n = state;
        cnt_n = cnt + one;
        line_n = line;
        latch = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                line_n = '0;
                if (go) begin
                    latch = 1'b1;
                    state_n = FV_SETUP;
                end
            end
            FV_SETUP: if (cnt == hb_s - one) begin
                cnt_n = '0;
                state_n = LINE_ACT;
            end
            LINE_ACT: if (cnt == width_s - one) begin
                cnt_n = '0;
                state_n = LINE_BLANK;
            end
            LINE_BLANK: if (cnt == hb_s - one) begin
                cnt_n = '0;
                line_n = (line == height_s - one) ? '0 : line + one;
                state_n = (line == height_s - one) ? V_BLANK : LINE_ACT;
            end
            V_BLANK: if (cnt == vb_s - one) begin
                cnt_n = '0;
                latch = go;
                state_n = go ? FV_SETUP : IDLE;
            end
            default: state_n = IDLE;
        endcase
        lp = line_n[0];
        cp = cnt_n[0];
        sum = cnt_n + line_n;
        flat_v = ((lp ^ cp) != g_even) ? g_s : ((lp ^ r_row0) ? r_s : b_s);
        pix_n = (state_n != LINE_ACT || !pat_ok) ? '0 : (ramp_s ? sum[SENSOR_DAT_WIDTH-1:0] : flat_v);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            line <= '0;
            width_s <= '0;
            height_s <= '0;
            hb_s <= one;
            vb_s <= one;
            r_s <= '0;
            g_s <= '0;
            b_s <= '0;
            ramp_s <= 1'b0;
            o_fval <= 1'b0;
            o_lval <= 1'b0;
            ov_pix_data <= '0;
            o_frame_done <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            line <= line_n;
            if (latch) begin
                width_s <= iv_width;
                height_s <= iv_height;
                hb_s <= (iv_h_blank == '0) ? one : iv_h_blank;
                vb_s <= (iv_v_blank == '0) ? one : iv_v_blank;
                r_s <= iv_r_value;
                g_s <= iv_g_value;
                b_s <= iv_b_value;
                ramp_s <= i_pattern_sel;
            end
            o_fval <= (state_n == FV_SETUP) || (state_n == LINE_ACT) || (state_n == LINE_BLANK);
            o_lval <= (state_n == LINE_ACT);
            ov_pix_data <= pix_n;
            o_frame_done <= (state == LINE_BLANK) && (state_n == V_BLANK);
        end
    end
endmodule

// File: tb/tb_wb_bayer_gen.sv
// tb_wb_bayer_gen: GR and BG generators driven side by side; whole-frame traces
// are compared against a frame model built from loops over lines and columns.
module tb_wb_bayer_gen;
    localparam int DW = 10;
    localparam int GW = 16;

    typedef logic [DW+2:0] smp_t;
    typedef struct {
        bit ramp;
        int w, h, hb, vb;
        int r, g, b;
        int fv_len;
        int spot_col, spot_gr, spot_bg;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, en = 1'b0, psel = 1'b0;
    logic [GW-1:0] w = '0, h = '0, hb = '0, vb = '0;
    logic [DW-1:0] r = '0, g = '0, b = '0;
    logic gr_fv, gr_lv, gr_done, bg_fv, bg_lv, bg_done;
    logic [DW-1:0] gr_pix, bg_pix;

    int passed = 0, total = 0;
    smp_t cap_gr[$], cap_bg[$], exp_gr[$], exp_bg[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    wb_bayer_gen #(.BAYER_PATTERN("GR"), .SENSOR_DAT_WIDTH(DW), .GEOM_WIDTH(GW)) u_gr (
        .clk(clk), .reset(reset), .i_enable(en), .i_pattern_sel(psel),
        .iv_width(w), .iv_height(h), .iv_h_blank(hb), .iv_v_blank(vb),
        .iv_r_value(r), .iv_g_value(g), .iv_b_value(b),
        .o_fval(gr_fv), .o_lval(gr_lv), .ov_pix_data(gr_pix), .o_frame_done(gr_done));

    wb_bayer_gen #(.BAYER_PATTERN("BG"), .SENSOR_DAT_WIDTH(DW), .GEOM_WIDTH(GW)) u_bg (
        .clk(clk), .reset(reset), .i_enable(en), .i_pattern_sel(psel),
        .iv_width(w), .iv_height(h), .iv_h_blank(hb), .iv_v_blank(vb),
        .iv_r_value(r), .iv_g_value(g), .iv_b_value(b),
        .o_fval(bg_fv), .o_lval(bg_lv), .ov_pix_data(bg_pix), .o_frame_done(bg_done));

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Row 1 swaps G with the colour that row 0 lacks.
    function automatic logic [DW-1:0] site(input string pat, input vec_t v, input int l, input int c);
        byte ch;
        if (v.ramp) return DW'(l + c);
        ch = pat[c % 2];
        if (l % 2 == 1) ch = (ch != "G") ? "G" : ((pat[0] == "R" || pat[1] == "R") ? "B" : "R");
        return (ch == "R") ? DW'(v.r) : (ch == "G") ? DW'(v.g) : DW'(v.b);
    endfunction

    task automatic build_exp(input vec_t v);
        int hbe = (v.hb == 0) ? 1 : v.hb;
        int vbe = (v.vb == 0) ? 1 : v.vb;
        exp_gr.delete();
        exp_bg.delete();
        for (int i = 0; i < hbe; i++) begin exp_gr.push_back({3'b100, DW'(0)}); exp_bg.push_back({3'b100, DW'(0)}); end
        for (int l = 0; l < v.h; l++) begin
            for (int c = 0; c < v.w; c++) begin
                exp_gr.push_back({3'b110, site("GR", v, l, c)});
                exp_bg.push_back({3'b110, site("BG", v, l, c)});
            end
            for (int i = 0; i < hbe; i++) begin exp_gr.push_back({3'b100, DW'(0)}); exp_bg.push_back({3'b100, DW'(0)}); end
        end
        for (int i = 0; i < vbe; i++) begin
            exp_gr.push_back({2'b00, i == 0, DW'(0)});
            exp_bg.push_back({2'b00, i == 0, DW'(0)});
        end
    endtask

    task automatic apply(input vec_t v);
        w = GW'(v.w); h = GW'(v.h); hb = GW'(v.hb); vb = GW'(v.vb);
        r = DW'(v.r); g = DW'(v.g); b = DW'(v.b); psel = v.ramp;
    endtask

    task automatic wait_rise(input string name);
        int k = 0;
        @(negedge clk);
        while (!gr_fv && k < 200) begin @(negedge clk); k++; end
        check({name, "_rise"}, int'(gr_fv), 1);
    endtask

    // ev_kind 1: width -> 8, ev_kind 2: drop enable; applied at sample ev_at.
    task automatic capture(input int n, input int ev_at, input int ev_kind);
        cap_gr.delete();
        cap_bg.delete();
        for (int i = 0; i < n; i++) begin
            if (i == ev_at && ev_kind == 1) w = GW'(8);
            if (i == ev_at && ev_kind == 2) en = 1'b0;
            cap_gr.push_back({gr_fv, gr_lv, gr_done, gr_pix});
            cap_bg.push_back({bg_fv, bg_lv, bg_done, bg_pix});
            @(negedge clk);
        end
    endtask

    task automatic cmp_trace(input string name);
        int bad_g = -1, bad_b = -1;
        for (int i = exp_gr.size() - 1; i >= 0; i--) begin
            if (cap_gr[i] !== exp_gr[i]) bad_g = i;
            if (cap_bg[i] !== exp_bg[i]) bad_b = i;
        end
        total += 2;
        if (bad_g < 0) passed++;
        else $display("FAIL %s_gr: cycle %0d got fv/lv/done/pix %h expected %h", name, bad_g, cap_gr[bad_g], exp_gr[bad_g]);
        if (bad_b < 0) passed++;
        else $display("FAIL %s_bg: cycle %0d got fv/lv/done/pix %h expected %h", name, bad_b, cap_bg[bad_b], exp_bg[bad_b]);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int fv = 0, dn = 0, idle = 0;
        int hbe = (v.hb == 0) ? 1 : v.hb;
        apply(v);
        en = 1'b1;
        wait_rise(name);
        en = 1'b0;
        build_exp(v);
        capture(exp_gr.size(), -1, 0);
        cmp_trace(name);
        foreach (cap_gr[i]) begin fv += int'(cap_gr[i][DW+2]); dn += int'(cap_gr[i][DW]); end
        check({name, "_fval_len"}, fv, v.fv_len);
        check({name, "_done_cnt"}, dn, 1);
        check({name, "_spot_gr"}, int'(cap_gr[hbe + v.spot_col][DW-1:0]), v.spot_gr);
        check({name, "_spot_bg"}, int'(cap_bg[hbe + v.spot_col][DW-1:0]), v.spot_bg);
        repeat (3) begin @(negedge clk); idle += int'(gr_fv | bg_fv); end
        check({name, "_idle"}, idle, 0);
    endtask

    initial begin
        vec_t v;
        int k, dn, seen;
        tbl.push_back('{1'b0, 4, 2, 2, 3, 'h100, 'h080, 'h040, 14, 1, 'h100, 'h080});
        tbl.push_back('{1'b0, 4, 2, 0, 3, 'h100, 'h080, 'h040, 11, 0, 'h080, 'h040});
        tbl.push_back('{1'b1, 1030, 1, 1, 1, 0, 0, 0, 1032, 1024, 0, 0});
        tbl.push_back('{1'b0, 3, 3, 1, 0, 'h3ff, 'h155, 'h2aa, 13, 2, 'h155, 'h2aa});
        tbl.push_back('{1'b1, 1, 1, 5, 2, 0, 0, 0, 11, 0, 0, 0});
        for (int i = 0; i < 6; i++) begin
            v.ramp = ($urandom_range(0, 1) == 1);
            v.w = $urandom_range(1, 12); v.h = $urandom_range(1, 4);
            v.hb = $urandom_range(0, 4); v.vb = $urandom_range(0, 4);
            v.r = $urandom_range(0, 1023); v.g = $urandom_range(0, 1023); v.b = $urandom_range(0, 1023);
            v.fv_len = ((v.hb == 0) ? 1 : v.hb) * (v.h + 1) + v.h * v.w;
            v.spot_col = $urandom_range(0, v.w - 1);
            v.spot_gr = int'(site("GR", v, 0, v.spot_col));
            v.spot_bg = int'(site("BG", v, 0, v.spot_col));
            tbl.push_back(v);
        end

        repeat (3) @(negedge clk);
        check("reset_outs", int'({gr_fv, gr_lv, gr_done, gr_pix}), 0);
        check("reset_outs_bg", int'({bg_fv, bg_lv, bg_done, bg_pix}), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outs", int'({gr_fv, gr_lv, gr_done, gr_pix}), 0);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // width change mid-frame, then enable dropped during line 1 of the next frame
        v = tbl[0];
        apply(v);
        en = 1'b1;
        wait_rise("wchg");
        build_exp(v);
        capture(exp_gr.size(), 5, 1);
        cmp_trace("wchg_old");
        check("wchg_next_rise", int'(gr_fv), 1);
        v.w = 8;
        build_exp(v);
        capture(exp_gr.size(), 15, 2);
        cmp_trace("wchg_new");
        seen = 0;
        repeat (10) begin @(negedge clk); seen += int'(gr_fv); end
        check("drop_idle_hold", seen, 0);
        en = 1'b1;
        @(negedge clk);
        check("reenable_rise", int'(gr_fv), 1);
        k = 0; dn = 0;
        do begin @(negedge clk); k++; dn += int'(gr_done); end while (!(gr_fv && !cap_gr[0][DW+2]) && k < 100 && !(gr_fv && k > 1 && dn > 0));
        check("period", k, 25);
        check("period_done", dn, 1);
        en = 1'b0;
        repeat (40) @(negedge clk);

        // zero width never starts a frame
        v = tbl[0];
        apply(v);
        w = '0;
        en = 1'b1;
        seen = 0;
        repeat (20) begin @(negedge clk); seen += int'(gr_fv | gr_lv | gr_done | (gr_pix != 0)); end
        check("zero_width_idle", seen, 0);
        en = 1'b0;
        @(negedge clk);

        // reset in the middle of an active line
        apply(v);
        en = 1'b1;
        wait_rise("rst");
        k = 0;
        while (!gr_lv && k < 50) begin @(negedge clk); k++; end
        check("rst_lval_seen", int'(gr_lv), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_async_outs", int'({gr_fv, gr_lv, gr_pix}), 0);
        seen = 0;
        repeat (2) begin @(negedge clk); seen += int'(gr_done | bg_done); end
        check("rst_no_done", seen, 0);
        reset = 1'b0;
        wait_rise("rst_restart");
        en = 1'b0;
        build_exp(v);
        capture(exp_gr.size(), -1, 0);
        cmp_trace("rst_restart");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/wb_bayer_gen.md
Name: wb_bayer_gen

Overview:
Bayer-stream source that produces sensor-format timing (fval/lval) and raw pixel data in a selectable Bayer order. It is the transmit-side counterpart of the data-channel Bayer splitter. It acts as the in-camera test-pattern source feeding the raw/white-balance path, so downstream colour classification and gain stages can be exercised with known R/G/B content. Frame geometry and colour values are programmable and are latched per frame.

Parameters:
BAYER_PATTERN, "GR", Bayer order of line 0: "GR", "RG", "GB" or "BG". Any other value forces ov_pix_data to 0; timing is still generated.
SENSOR_DAT_WIDTH, 10, pixel data width.
GEOM_WIDTH, 16, width of all geometry/blanking inputs and of the internal counters.

Ports:
clk  in  1  processing clock
reset  in  1  asynchronous, active-high reset
i_enable  in  1  run request; level-sensitive
i_pattern_sel  in  1  0 = flat colour per Bayer site; 1 = ramp
iv_width  in  GEOM_WIDTH  active pixels per line
iv_height  in  GEOM_WIDTH  active lines per frame
iv_h_blank  in  GEOM_WIDTH  line blanking cycles
iv_v_blank  in  GEOM_WIDTH  frame blanking cycles (fval low)
iv_r_value  in  SENSOR_DAT_WIDTH  R site value
iv_g_value  in  SENSOR_DAT_WIDTH  G site value
iv_b_value  in  SENSOR_DAT_WIDTH  B site value
o_fval  out  1  frame valid
o_lval  out  1  line valid
ov_pix_data  out  SENSOR_DAT_WIDTH  pixel data
o_frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset (async, active-high): all outputs are 0 immediately, the FSM goes to IDLE and all counters clear. Reset asserted mid-line or mid-frame truncates the output with no completion pulse.
- All outputs are registered.
- States: IDLE, FV_SETUP, LINE_ACT, LINE_BLANK, V_BLANK.
- IDLE
  - o_fval = 0 and o_lval = 0.
  - If i_enable = 1 and iv_width != 0 and iv_height != 0: latch all iv_* inputs and i_pattern_sel into shadow registers, then go to FV_SETUP.
  - o_fval = 1 on the clock edge after i_enable is sampled high.
  - A zero width or zero height keeps the FSM in IDLE.
- Blanking of 0 is treated as 1 for both h_blank and v_blank.
- FV_SETUP: o_fval = 1, o_lval = 0 for h_blank cycles, then go to LINE_ACT.
- LINE_ACT: o_lval = 1 for exactly width cycles. The column counter runs 0..width-1. Then go to LINE_BLANK.
- LINE_BLANK
  - o_lval = 0 for h_blank cycles and the line counter increments.
  - If the completed line was line height-1, o_fval falls at the end of this blank and the FSM goes to V_BLANK. Otherwise it returns to LINE_ACT.
- o_fval high duration = h_blank + height*(width + h_blank) cycles.
- o_frame_done: asserted for 1 cycle, coincident with the first cycle of o_fval = 0 after a frame.
- V_BLANK
  - o_fval = 0 for v_blank cycles.
  - Then, if i_enable = 1, re-latch the shadows and go to FV_SETUP; otherwise go to IDLE.
- Deasserting i_enable mid-frame has no effect on the current frame. The frame and its V_BLANK complete before IDLE.
- Changes to iv_* or i_pattern_sel mid-frame are ignored until the next latch.
- Pixel data
  - ov_pix_data = 0 whenever o_lval = 0.
  - Site selection uses the line parity (line counter bit 0) and the column parity (column counter bit 0).
  - The line-0 order comes from BAYER_PATTERN. Line 1 uses the complementary row, e.g. GR gives line 0 = G R G R and line 1 = B G B G.
  - Flat mode: data = the latched value for that site.
  - Ramp mode: data = (column + line) truncated to SENSOR_DAT_WIDTH; this wraps modulo 2^SENSOR_DAT_WIDTH.
- Counters are GEOM_WIDTH wide. Width/height/blanking up to 2^GEOM_WIDTH-1 are supported without overflow.

Test Plan:
- GR, flat; width 4, height 2, h_blank 2, v_blank 3; r = 0x100, g = 0x080, b = 0x040 -> line 0 data 080,100,080,100; line 1 data 040,080,040,080; o_fval high 14 cycles; frame period 17; one o_frame_done pulse per frame.
- BG instance with the same settings -> line 0 = 040,080,040,080; line 1 = 080,100,080,100. Ramp mode, width 1030, SENSOR_DAT_WIDTH 10 -> line 0 pixel 1024 = 0x000 (wrap).
- i_enable dropped during line 1 of 2 -> that frame completes fully, V_BLANK completes, then IDLE with o_fval held 0. Re-enable -> o_fval rises one cycle later.
- iv_width changed from 4 to 8 mid-frame -> current frame keeps 4-pixel lines; the next frame has 8-pixel lines.
- iv_width = 0 with i_enable = 1 -> stays IDLE with all outputs 0. iv_h_blank = 0 -> behaves identically to h_blank = 1.
- reset pulsed mid-LINE_ACT -> o_fval, o_lval and ov_pix_data go to 0 asynchronously with no o_frame_done. After release with i_enable high, a new frame starts from line 0, column 0.
